// File: rtl/li_expander_pkg.sv
// rtl/li_expander_pkg.sv - shared opcode constants and FSM state encoding for li_expander
// Also consumed by the immediate and control decoders.
package li_expander_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EMIT_LUI  = 2'd1,
    ST_EMIT_ADDI = 2'd2
  } state_e;

endpackage

// File: rtl/li_expander_split.sv
// rtl/li_expander_split.sv - combinational LUI/ADDI split and encoding for li_expander
// Single-beat selection exists only when LI_COMPRESS_EN is defined.
module li_split
  import li_expander_pkg::*;
(
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] value_i,
  output logic [31:0]     first_word_o,
  output logic            first_last_o,
  output logic [31:0]     addi_word_o
);

  logic [19:0] hi20;
  logic [11:0] lo12;
  logic [31:0] lui_word;

  // Adding bit 11 into the upper part is (value + 0x800) >> 12, modulo 2^20.
  assign lo12     = value_i[11:0];
  assign hi20     = value_i[31:12] + {19'b0, value_i[11]};
  assign lui_word = {hi20, rd_i, OP_LUI};

  assign addi_word_o = {lo12, rd_i, FUNCT3_ADDI, rd_i, OP_IMM};

`ifdef LI_COMPRESS_EN
  always_comb begin
    first_word_o = lui_word;
    first_last_o = 1'b0;
    if (hi20 == 20'h0) begin
      first_word_o = {lo12, 5'd0, FUNCT3_ADDI, rd_i, OP_IMM};
      first_last_o = 1'b1;
    end else if (lo12 == 12'h0) begin
      first_last_o = 1'b1;
    end
  end
`else
  assign first_word_o = lui_word;
  assign first_last_o = 1'b0;
`endif

endmodule

// File: rtl/li_expander.sv
// rtl/li_expander.sv - load-immediate expander: {rd, value} in, LUI/ADDI instruction beats out
// LI_COMPRESS_EN selects single-beat forms where the constant allows it.
module li_expander
  import li_expander_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_value,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic            o_last
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic [31:0] addi_q, addi_d;

  logic [31:0] first_word;
  logic        first_last;
  logic [31:0] addi_word;
  logic        accept;
  logic        out_fire;

  li_split u_split (
    .rd_i         (i_rd),
    .value_i      (i_value),
    .first_word_o (first_word),
    .first_last_o (first_last),
    .addi_word_o  (addi_word)
  );

  // The ADDI slot frees up in the same cycle it is consumed, allowing back-to-back requests.
  assign o_ready  = !i_rst && ((state_q == ST_IDLE) || (state_q == ST_EMIT_ADDI && i_ready));
  assign accept   = i_valid && o_ready;
  assign out_fire = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    addi_d  = addi_q;
    case (state_q)
      ST_EMIT_LUI: begin
        if (out_fire) begin
          state_d = ST_EMIT_ADDI;
          instr_d = addi_q;
          last_d  = 1'b1;
        end
      end
      ST_EMIT_ADDI: begin
        if (out_fire) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d = first_last ? ST_EMIT_ADDI : ST_EMIT_LUI;
      valid_d = 1'b1;
      instr_d = first_word;
      last_d  = first_last;
      addi_d  = addi_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
      addi_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      addi_q  <= addi_d;
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_li_expander.sv
// tb/tb_li_expander.sv - directed self-checking bench for li_expander
// Expectations switch with LI_COMPRESS_EN to match the selected build.
module tb_li_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic [31:0] i_value;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_last;

  int n_cmp  = 0;
  int n_fail = 0;

  li_expander dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_rd    (i_rd),
    .i_value (i_value),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_instr (o_instr),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_rd = 5'd0; i_value = 32'h0;
    tick(); tick();
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", o_instr); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", o_last); end
    rst = 1'b0;
    tick();
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", o_ready); end
  endtask

  task automatic test_pair(input string name, input logic [4:0] rd, input logic [31:0] value,
                           input logic [31:0] exp_lui, input logic [31:0] exp_addi);
    i_rd = rd; i_value = value; i_valid = 1'b1; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, o_ready); end
    tick();
    i_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL %s lui_valid: got %b want 1", name, o_valid); end
    n_cmp++; if (o_instr !== exp_lui) begin n_fail++; $display("FAIL %s lui_instr: got %h want %h", name, o_instr, exp_lui); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL %s lui_last: got %b want 0", name, o_last); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL %s lui_ready: got %b want 0", name, o_ready); end
    tick();
    n_cmp++; if (o_instr !== exp_addi) begin n_fail++; $display("FAIL %s addi_instr: got %h want %h", name, o_instr, exp_addi); end
    n_cmp++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL %s addi_last: got %b want 1", name, o_last); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL %s addi_ready: got %b want 1", name, o_ready); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL %s done_valid: got %b want 0", name, o_valid); end
  endtask

`ifdef LI_COMPRESS_EN
  task automatic test_single(input string name, input logic [4:0] rd, input logic [31:0] value,
                             input logic [31:0] exp);
    i_rd = rd; i_value = value; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL %s valid: got %b want 1", name, o_valid); end
    n_cmp++; if (o_instr !== exp) begin n_fail++; $display("FAIL %s instr: got %h want %h", name, o_instr, exp); end
    n_cmp++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL %s last: got %b want 1", name, o_last); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL %s done_valid: got %b want 0", name, o_valid); end
  endtask
`endif

  task automatic test_back_to_back();
`ifdef LI_COMPRESS_EN
    i_rd = 5'd3; i_value = 32'h0000_1000; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_rd = 5'd2; i_value = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (o_instr !== 32'h000011B7) begin n_fail++; $display("FAIL b2b_first: got %h want 000011B7", o_instr); end
    n_cmp++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL b2b_first_last: got %b want 1", o_last); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    #1;
    n_cmp++; if (o_instr !== 32'hFFF00113) begin n_fail++; $display("FAIL b2b_second: got %h want FFF00113", o_instr); end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", o_valid); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_valid: got %b want 0", o_valid); end
`else
    i_rd = 5'd1; i_value = 32'h0000_0800; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_rd = 5'd5; i_value = 32'h1234_5678;
    #1;
    n_cmp++; if (o_instr !== 32'h000010B7) begin n_fail++; $display("FAIL b2b_lui_a: got %h want 000010B7", o_instr); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_lui_a_ready: got %b want 0", o_ready); end
    tick();
    n_cmp++; if (o_instr !== 32'h80008093) begin n_fail++; $display("FAIL b2b_addi_a: got %h want 80008093", o_instr); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_addi_a_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    #1;
    n_cmp++; if (o_instr !== 32'h123452B7) begin n_fail++; $display("FAIL b2b_lui_b: got %h want 123452B7", o_instr); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL b2b_lui_b_last: got %b want 0", o_last); end
    tick();
    n_cmp++; if (o_instr !== 32'h67828293) begin n_fail++; $display("FAIL b2b_addi_b: got %h want 67828293", o_instr); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_valid: got %b want 0", o_valid); end
`endif
  endtask

  task automatic test_backpressure();
    i_rd = 5'd5; i_value = 32'h1234_5678; i_valid = 1'b1; i_ready = 1'b0;
    tick();
    i_rd = 5'd9; i_value = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (o_instr !== 32'h123452B7) begin n_fail++; $display("FAIL bp_hold_instr[%0d]: got %h want 123452B7", k, o_instr); end
      n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL bp_hold_last[%0d]: got %b want 0", k, o_last); end
      n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", k, o_ready); end
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_instr !== 32'h123452B7) begin n_fail++; $display("FAIL bp_release_instr: got %h want 123452B7", o_instr); end
    tick();
    n_cmp++; if (o_instr !== 32'h67828293) begin n_fail++; $display("FAIL bp_addi_instr: got %h want 67828293", o_instr); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %b want 0", o_valid); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_ghost: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    i_rd = 5'd5; i_value = 32'h1234_5678; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    i_ready = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", o_ready); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr: got %h want 00000000", o_instr); end
    rst = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", o_ready); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_addi: got %b want 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_pair("basic", 5'd5, 32'h1234_5678, 32'h123452B7, 32'h67828293);
    test_pair("carry", 5'd1, 32'h0000_0800, 32'h000010B7, 32'h80008093);
`ifdef LI_COMPRESS_EN
    test_single("wrap", 5'd2, 32'hFFFF_FFFF, 32'hFFF00113);
    test_single("lui_only", 5'd3, 32'h0000_1000, 32'h000011B7);
`else
    test_pair("wrap", 5'd2, 32'hFFFF_FFFF, 32'h00000137, 32'hFFF10113);
    test_pair("lo_zero", 5'd3, 32'h0000_1000, 32'h000011B7, 32'h00018193);
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
